// File: rtl/pwm_dither_dac_pkg.sv
// Shared constants for the dithered PWM DAC channels.
// Also used by the register block when packing the config word.
package pwm_dither_dac_pkg;

  localparam int DUTY_W   = 8;
  localparam int SEQ_LEN  = 16;
  localparam int CCW      = DUTY_W + SEQ_LEN;

  localparam int DUTY_MSB = CCW - 1;
  localparam int DUTY_LSB = SEQ_LEN;
  localparam int SEQ_MSB  = SEQ_LEN - 1;

endpackage

// File: rtl/pwm_dither_dac.sv
// One PWM DAC channel: 2**DUTY_W-clock periods, SEQ_LEN-period
// dither frame, config shadowed at frame boundaries.
module pwm_dither_dac #(
  parameter int DUTY_W  = pwm_dither_dac_pkg::DUTY_W,
  parameter int SEQ_LEN = pwm_dither_dac_pkg::SEQ_LEN,
  parameter bit INVERT  = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      en_i,
  input  logic [DUTY_W+SEQ_LEN-1:0] cfg_i,
  output logic                      pwm_o,
  output logic                      period_o,
  output logic                      frame_o,
  output logic [DUTY_W+SEQ_LEN-1:0] cfg_used_o
);

  localparam int CW    = DUTY_W + SEQ_LEN;
  localparam int IDX_W = $clog2(SEQ_LEN);

  logic [DUTY_W-1:0]  r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [CW-1:0]      r_shadow;
  logic               r_pwm;
  logic               r_period;
  logic               r_frame;

  logic [DUTY_W-1:0]  w_duty;
  logic [SEQ_LEN-1:0] w_seq;
  logic               w_dbit;
  logic [DUTY_W:0]    w_thr;
  logic               w_high;
  logic               w_last_cnt;
  logic               w_last_idx;
  logic               w_frame_end;

  assign w_duty      = r_shadow[CW-1:SEQ_LEN];
  assign w_seq       = r_shadow[SEQ_LEN-1:0];
  assign w_dbit      = w_seq[r_idx];
  // 9-bit threshold so duty 255 plus a dither bit reaches 256.
  assign w_thr       = {1'b0, w_duty} + (DUTY_W+1)'(w_dbit);
  assign w_high      = ({1'b0, r_cnt} < w_thr);
  assign w_last_cnt  = &r_cnt;
  assign w_last_idx  = (r_idx == IDX_W'(SEQ_LEN - 1));
  assign w_frame_end = w_last_cnt && w_last_idx;

  // Period counter and dither index; both held at zero while idle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!en_i) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last_cnt) r_idx <= r_idx + 1'b1;
    end
  end

  // Shadow tracks cfg_i while idle, otherwise reloads only at frame end.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_shadow <= '0;
    end else if (!en_i || w_frame_end) begin
      r_shadow <= cfg_i;
    end
  end

  // Registered compare and strobes, aligned to the same pre-edge count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pwm    <= INVERT;
      r_period <= 1'b0;
      r_frame  <= 1'b0;
    end else if (!en_i) begin
      r_pwm    <= INVERT;
      r_period <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_pwm    <= INVERT ^ w_high;
      r_period <= w_last_cnt;
      r_frame  <= w_frame_end;
    end
  end

  assign pwm_o      = r_pwm;
  assign period_o   = r_period;
  assign frame_o    = r_frame;
  assign cfg_used_o = r_shadow;

endmodule

// File: doc/pwm_dither_dac.md
Name: pwm_dither_dac

Overview:
- Consumes the 24-bit PWM configuration word from the analog-mixed-signal register block and drives one PWM DAC output pin.
- Word layout: cfg[23:16] is the 8-bit base duty; cfg[15:0] is a 16-entry dither sequence, and each entry adds one extra high cycle to one PWM period.
- Period is 256 clocks. Dither frame is 16 periods (4096 clocks).
- Four instances sit between the register block and the PWM pins (channels a..d).

Parameters:
- DUTY_W, 8, base duty width; PWM period = 2**DUTY_W clocks.
- SEQ_LEN, 16, dither sequence length in periods; CCW = DUTY_W+SEQ_LEN = 24.
- INVERT, 0, when 1, pwm_o is inverted after the compare (reset value becomes 1).

Ports:
- clk_i  in  1  PWM clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- en_i  in  1  run enable; low holds the generator idle.
- cfg_i  in  24  configuration word {duty[7:0], seq[15:0]}; already unsigned and encoded upstream.
- pwm_o  out  1  registered PWM output.
- period_o  out  1  one-cycle strobe on the last clock of each period.
- frame_o  out  1  one-cycle strobe on the last clock of each frame.
- cfg_used_o  out  24  shadow word currently applied, for readback.

Behaviour:
- Reset (async, rstn_i low): cnt=0, idx=0, shadow=0, pwm_o=INVERT, period_o=0, frame_o=0, cfg_used_o=0. Outputs take these values immediately, without a clock edge.
- State:
  - cnt: 8-bit, counts 0..255 and wraps.
  - idx: 4-bit period index, counts 0..15 and wraps.
  - shadow: 24-bit copy of cfg_i.
- Running (en_i=1), per rising edge:
  - cnt <= cnt+1 (wraps).
  - idx <= idx+1 when cnt==255.
  - pwm_o <= INVERT ^ ({1'b0,cnt} < {1'b0,shadow[23:16]} + shadow[idx]). This is a 9-bit compare, so duty+1 = 256 is allowed.
- Dither bit mapping: period idx uses seq bit idx (LSB first).
- Latency: pwm_o reflects the cnt/idx values present before the edge, i.e. one clock of lag.
- High time per period = duty + seq[idx], range 0..256. Duty 255 with bit 1 gives a constant-high period.
- period_o <= (cnt==255). frame_o <= (cnt==255 && idx==15). Both are registered, aligned with the pwm_o sample of that clock, and high for exactly one clock.
- Shadow load:
  - Loaded on the edge where cnt==255 && idx==15, so new settings apply from the next frame's first period.
  - cfg_i changes mid-frame have no effect on the running frame.
  - cfg_used_o = shadow.
- Idle (en_i=0):
  - cnt and idx forced to 0 and shadow <= cfg_i every clock.
  - pwm_o <= INVERT; period_o and frame_o stay 0.
  - On en_i rising, the first running edge starts at cnt=0, idx=0 using the shadow loaded on the last idle clock.
- en_i falling mid-period: the next edge goes idle. No completion of the period.
- After reset with en_i=1, the first frame runs with shadow=0 (output low for 4096 clocks) and loads cfg_i at the first frame end.
- Reset mid-operation: abort immediately; no partial state is retained.

Decomposition:
- Shared package: DUTY_W, SEQ_LEN, CCW, and field slice constants DUTY_MSB=23, DUTY_LSB=16, SEQ_MSB=15. The register block uses the same package for its encoder.
- Single module; no sub-module. The counter and compare are too small to split.

Test Plan:
- Duty 50%: cfg_i=24'h800000, en_i=1, run 3 frames. From frame 2 on, each period has 128 high / 128 low, and frame_o pulses every 4096 clocks.
- Dither: cfg_i=24'h405555. In frame 2, even-idx periods have 65 high, odd-idx periods have 64 high, and the frame total is 1032 high clocks.
- Extremes:
  - cfg_i=24'hFFFFFF gives constant 1 over a full frame.
  - cfg_i=24'h000000 gives constant 0.
  - cfg_i=24'hFF0000 gives 255 high + 1 low per period.
- Mid-frame change: switch cfg_i from 24'h800000 to 24'h200000 at cnt=100, idx=5. The high count stays 128 through idx=15, and cfg_used_o updates to 24'h200000 on the frame-end edge. The next period has 32 high.
- Enable: drop en_i at cnt=50. pwm_o goes 0 next clock, and cnt/idx read 0. Set cfg_i=24'h100000 and raise en_i; the first period is 16 high, starting at cnt=0.
- Async reset: assert rstn_i between clock edges while pwm_o=1. pwm_o, cfg_used_o and the strobes go 0 without a clock edge. After release, the output stays low for one full frame.
